// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Brief    : Control FSM sequencing a multicycle MIPS datapath (3-5 cycles per
//            instruction) with memory ready handshake and bus-error timeout.
// Revision : 1.0  initial release
// ============================================================================
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] OP_code,
    input  logic [5:0] Function_field,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNE,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOP,
    output logic       Sign,
    output logic [1:0] PCSource,
    output logic [3:0] state_o,
    output logic       illegal,
    output logic       bus_err
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_IMM_EXEC  = 4'd10,
        S_IMM_WB    = 4'd11,
        S_JR        = 4'd12,
        S_JAL       = 4'd13,
        S_TRAP      = 4'd14
    } state_t;

    localparam int              c_CW   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(MEM_TIMEOUT - 1);

    state_t          r_state;
    state_t          w_next;
    logic [c_CW-1:0] r_wait;
    logic            r_illegal;
    logic            r_bus_err;
    logic            w_waiting;
    logic            w_timeout;
    logic            w_set_illegal;

    // States that hold the memory port until mem_ready
    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                       (r_state == S_MEM_WRITE);
    assign w_timeout = w_waiting && !mem_ready && (r_wait == c_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait <= '0;
            else if (w_waiting && !mem_ready)
                r_wait <= r_wait + 1'b1;
            if (w_set_illegal)
                r_illegal <= 1'b1;
            if (w_timeout)
                r_bus_err <= 1'b1;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_set_illegal = 1'b0;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        BranchNE      = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegDst        = 2'b00;
        MemtoReg      = 2'b00;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUOP         = 3'b000;
        Sign          = 1'b0;
        PCSource      = 2'b00;

        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready)      w_next = S_DECODE;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                Sign    = 1'b1;
                case (OP_code)
                    6'd0: begin
                        if (Function_field == 6'd8)       w_next = S_JR;
                        else if (Function_field == 6'd32) w_next = S_R_EXEC;
                        else begin
                            w_next        = S_TRAP;
                            w_set_illegal = 1'b1;
                        end
                    end
                    6'd2:                    w_next = S_JUMP;
                    6'd3:                    w_next = S_JAL;
                    6'd4, 6'd5:              w_next = S_BRANCH;
                    6'd8, 6'd10, 6'd12,
                    6'd13, 6'd14, 6'd15:     w_next = S_IMM_EXEC;
                    6'd35, 6'd43:            w_next = S_MEM_ADDR;
                    default: begin
                        w_next        = S_TRAP;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                Sign    = 1'b1;
                w_next  = (OP_code == 6'd35) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (mem_ready)      w_next = S_MEM_WB;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_MEM_WB: begin
                MemtoReg = 2'b01;
                RegWrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEM_WRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready)      w_next = S_FETCH;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOP   = 3'b010;
                w_next  = S_R_WB;
            end
            S_R_WB: begin
                RegDst   = 2'b01;
                RegWrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOP       = 3'b001;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BranchNE    = (OP_code == 6'd5);
                w_next      = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                w_next   = S_FETCH;
            end
            S_IMM_EXEC, S_IMM_WB: begin
                // ALU operation stays decoded from OP_code through writeback
                case (OP_code)
                    6'd10:   begin ALUOP = 3'b011; Sign = 1'b1; end
                    6'd12:   ALUOP = 3'b100;
                    6'd13:   ALUOP = 3'b101;
                    6'd14:   ALUOP = 3'b110;
                    6'd15:   ALUOP = 3'b111;
                    default: begin ALUOP = 3'b000; Sign = 1'b1; end
                endcase
                if (r_state == S_IMM_EXEC) begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    w_next  = S_IMM_WB;
                end else begin
                    RegWrite = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_JR: begin
                PCWrite  = 1'b1;
                PCSource = 2'b11;
                w_next   = S_FETCH;
            end
            S_JAL: begin
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                w_next   = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_TRAP;
        endcase
    end

    assign state_o = r_state;
    assign illegal = r_illegal;
    assign bus_err = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_ctrl
// Brief    : Directed self-checking bench for mips_multicycle_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] OP_code;
    logic [5:0] Function_field;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite;
    logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
    logic       RegWrite, ALUSrcA, Sign, illegal, bus_err;
    logic [2:0] ALUOP;
    logic [3:0] state_o;

    int errors = 0;
    int checks = 0;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .OP_code(OP_code),
        .Function_field(Function_field), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOP(ALUOP), .Sign(Sign),
        .PCSource(PCSource), .state_o(state_o), .illegal(illegal),
        .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; OP_code = 6'd0; Function_field = 6'd0; mem_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);

        // lw: 0,1,2,3,4,0
        OP_code = 6'd35; #1;
        chk("lw_f_irw", {IRWrite, PCWrite, MemRead, IorD}, 32'b1110);
        chk("lw_f_alu", {ALUSrcA, ALUSrcB, ALUOP, PCSource}, 32'b0_01_000_00);
        tick(); chk("lw_s1", 32'(state_o), 32'd1);
        chk("lw_dec", {ALUSrcA, ALUSrcB, ALUOP, Sign}, 32'b0_11_000_1);
        tick(); chk("lw_s2", 32'(state_o), 32'd2);
        chk("lw_addr", {ALUSrcA, ALUSrcB, Sign}, 32'b1_10_1);
        tick(); chk("lw_s3", 32'(state_o), 32'd3);
        chk("lw_rd", {IorD, MemRead, RegWrite}, 32'b110);
        tick(); chk("lw_s4", 32'(state_o), 32'd4);
        chk("lw_wb", {MemtoReg, RegWrite, RegDst}, 32'b01_1_00);
        tick(); chk("lw_s0", 32'(state_o), 32'd0);
        chk("lw_f_rw", {RegWrite, MemtoReg}, 32'b0_00);

        // add: 0,1,6,7,0
        OP_code = 6'd0; Function_field = 6'd32;
        tick(); tick(); chk("add_s6", 32'(state_o), 32'd6);
        chk("add_alu", {ALUOP, ALUSrcA, ALUSrcB}, 32'b010_1_00);
        tick(); chk("add_s7", 32'(state_o), 32'd7);
        chk("add_wb", {RegDst, MemtoReg, RegWrite}, 32'b01_00_1);
        tick(); chk("add_s0", 32'(state_o), 32'd0);

        // jr: 0,1,12,0
        Function_field = 6'd8;
        tick(); tick(); chk("jr_s12", 32'(state_o), 32'd12);
        chk("jr_pc", {PCSource, PCWrite}, 32'b11_1);
        tick(); chk("jr_s0", 32'(state_o), 32'd0);

        // bne
        OP_code = 6'd5;
        tick(); tick(); chk("bne_s8", 32'(state_o), 32'd8);
        chk("bne_ctl", {PCWriteCond, BranchNE, ALUOP, PCSource, PCWrite}, 32'b1_1_001_01_0);
        tick(); chk("bne_s0", 32'(state_o), 32'd0);

        // beq uses BranchNE=0
        OP_code = 6'd4;
        tick(); tick(); chk("beq_ne", {PCWriteCond, BranchNE}, 32'b10);
        tick();

        // ori
        OP_code = 6'd13;
        tick(); tick(); chk("ori_s10", 32'(state_o), 32'd10);
        chk("ori_ctl", {ALUOP, Sign, ALUSrcA, ALUSrcB}, 32'b101_0_1_10);
        tick(); chk("ori_s11", 32'(state_o), 32'd11);
        chk("ori_wb", {RegWrite, RegDst, MemtoReg, ALUOP, Sign}, 32'b1_00_00_101_0);
        tick();

        // slti
        OP_code = 6'd10;
        tick(); tick(); chk("slti_ctl", {ALUOP, Sign}, 32'b011_1);
        tick(); tick();

        // jal
        OP_code = 6'd3;
        tick(); tick(); chk("jal_s13", 32'(state_o), 32'd13);
        chk("jal_ctl", {RegDst, MemtoReg, RegWrite, PCWrite, PCSource}, 32'b10_10_1_1_10);
        tick(); chk("jal_s0", 32'(state_o), 32'd0);

        // FETCH stalled 3 cycles then ready
        mem_ready = 1'b0; OP_code = 6'd2; #1;
        for (int i = 0; i < 3; i++) begin
            chk("fw_wait", {state_o, MemRead, IRWrite, PCWrite}, {4'd0, 3'b100});
            tick();
        end
        mem_ready = 1'b1; #1;
        chk("fw_go", {state_o, MemRead, IRWrite, PCWrite}, {4'd0, 3'b111});
        tick(); chk("fw_dec", 32'(state_o), 32'd1);
        tick(); chk("j_s9", {state_o, PCWrite, PCSource}, {4'd9, 3'b110});
        tick();

        // lw with 15 waits then ready on the last permitted cycle
        OP_code = 6'd35;
        tick(); tick();
        mem_ready = 1'b0;
        tick(); chk("lwb_s3", 32'(state_o), 32'd3);
        for (int i = 0; i < 15; i++) tick();
        chk("lwb_s3_hold", {state_o, bus_err}, {4'd3, 1'b0});
        mem_ready = 1'b1;
        tick(); chk("lwb_s4", {state_o, bus_err}, {4'd4, 1'b0});
        tick();

        // sw timeout
        OP_code = 6'd43;
        tick(); tick();
        mem_ready = 1'b0;
        tick(); chk("sw_s5", {state_o, MemWrite, IorD}, {4'd5, 2'b11});
        for (int i = 0; i < 15; i++) tick();
        chk("sw_s5_last", {state_o, bus_err}, {4'd5, 1'b0});
        tick(); chk("sw_trap", {state_o, bus_err, illegal}, {4'd14, 2'b10});
        chk("trap_ctl", {MemWrite, MemRead, PCWrite, RegWrite}, 32'd0);
        mem_ready = 1'b1;
        tick(); chk("trap_hold", {state_o, bus_err}, {4'd14, 1'b1});

        rst_n = 1'b0; tick(); rst_n = 1'b1; #1;
        chk("rst2", {state_o, bus_err, illegal}, {4'd0, 2'b00});

        // illegal opcode
        OP_code = 6'd63;
        tick(); tick(); chk("ill_trap", {state_o, illegal, PCWrite}, {4'd14, 2'b10});
        tick(); chk("ill_hold", {state_o, illegal, PCWrite, IRWrite}, {4'd14, 3'b100});

        rst_n = 1'b0; tick(); rst_n = 1'b1; #1;
        chk("rst3", {state_o, illegal}, {4'd0, 1'b0});

        // op0 with unsupported funct
        OP_code = 6'd0; Function_field = 6'd33;
        tick(); tick(); chk("ill_funct", {state_o, illegal}, {4'd14, 1'b1});
        rst_n = 1'b0; tick(); rst_n = 1'b1;

        // reset during R_EXEC
        Function_field = 6'd32; #1;
        tick(); tick(); chk("rr_s6", {state_o, RegWrite}, {4'd6, 1'b0});
        rst_n = 1'b0; mem_ready = 1'b0;
        tick(); #1;
        chk("rr_fetch", {state_o, RegWrite, PCWrite, IRWrite, MemWrite}, {4'd0, 4'b0000});
        rst_n = 1'b1;
        tick(); chk("rr_stay", {state_o, RegWrite}, {4'd0, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Moore/Mealy control FSM that sequences the multicycle MIPS datapath (shared memory port, IR, A/B, ALUOut, PC) over 3-5 cycles per instruction. It replaces the single-cycle decoder in the multicycle core variant and supports the same instruction subset: R-type add/jr, j, jal, beq, bne, addi, slti, andi, ori, xori, lui, lw, sw. Memory accesses use a ready handshake with a bus-error timeout.

Parameters:
MEM_TIMEOUT, 16, max consecutive wait cycles with mem_ready=0 before a bus-error trap (>=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous, active-low reset
OP_code  in  6  IR[31:26]
Function_field  in  6  IR[5:0]
mem_ready  in  1  memory completes access this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  conditional PC load (datapath gates with Zero^BranchNE)
BranchNE  out  1  1=bne, 0=beq
IorD  out  1  0=PC address, 1=ALUOut address
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  load IR
RegDst  out  2  00=rt, 01=rd, 10=r31
MemtoReg  out  2  00=ALUOut, 01=MDR, 10=PC
RegWrite  out  1  register file write
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  2  00=B, 01=4, 10=ext imm, 11=ext imm<<2
ALUOP  out  3  000 add, 001 sub, 010 funct, 011 slt, 100 and, 101 or, 110 xor, 111 lui
Sign  out  1  1=sign-extend imm, 0=zero-extend
PCSource  out  2  00=ALU, 01=ALUOut, 10=jump target, 11=A
state_o  out  4  current state encoding
illegal  out  1  sticky illegal-opcode flag
bus_err  out  1  sticky memory-timeout flag

Behaviour:
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, IMM_EXEC=10, IMM_WB=11, JR=12, JAL=13, TRAP=14.
- Reset (rst_n=0 at edge): state=FETCH, wait counter=0, illegal=0, bus_err=0. All control outputs are combinational from state (+mem_ready); unlisted outputs are 0 in every state.
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOP=000, PCSource=00; IRWrite=PCWrite=mem_ready. Stay while mem_ready=0; on mem_ready=1 -> DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOP=000, Sign=1. Next: op0&funct8->JR; op0&funct32->R_EXEC; op2->JUMP; op3->JAL; op4/5->BRANCH; op8,10,12,13,14,15->IMM_EXEC; op35/43->MEM_ADDR; else ->TRAP, set illegal (op0 with any other funct is illegal).
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOP=000, Sign=1; op35->MEM_READ, op43->MEM_WRITE.
- MEM_READ: IorD=1, MemRead=1; wait on mem_ready -> MEM_WB. MEM_WB: RegDst=00, MemtoReg=01, RegWrite=1 -> FETCH.
- MEM_WRITE: IorD=1, MemWrite=1; wait on mem_ready -> FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOP=010 -> R_WB. R_WB: RegDst=01, MemtoReg=00, RegWrite=1 -> FETCH.
- IMM_EXEC: ALUSrcA=1, ALUSrcB=10; ALUOP/Sign: addi 000/1, slti 011/1, andi 100/0, ori 101/0, xori 110/0, lui 111/0 -> IMM_WB. IMM_WB: RegDst=00, MemtoReg=00, RegWrite=1 -> FETCH. ALUOP/Sign stay driven from OP_code in IMM_WB.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOP=001, PCWriteCond=1, PCSource=01, BranchNE=(OP_code==5) -> FETCH.
- JUMP: PCWrite=1, PCSource=10 -> FETCH. JR: PCWrite=1, PCSource=11 -> FETCH.
- JAL: RegDst=10, MemtoReg=10, RegWrite=1, PCWrite=1, PCSource=10 -> FETCH. PC still holds PC+4 this cycle.
- Wait counter: cleared on entry to FETCH/MEM_READ/MEM_WRITE. Increments each cycle in these states with mem_ready=0. If mem_ready=0 in the cycle the counter equals MEM_TIMEOUT-1 -> TRAP, set bus_err. mem_ready=1 in that same cycle wins (normal advance).
- TRAP: all controls 0; stays until reset. illegal/bus_err hold.
- Reset asserted mid-instruction overrides all transitions; no write strobe is asserted in the reset cycle's following state (FETCH with mem_ready=0).

Test Plan:
- Reset, mem_ready=1, OP_code=35 -> state_o sequence 0,1,2,3,4,0 (5 cycles). MemtoReg=01 and RegWrite=1 only in state 4.
- OP_code=0/funct=32, then OP_code=0/funct=8 -> 0,1,6,7,0 with ALUOP=010 in 6; then 0,1,12,0 with PCSource=11, PCWrite=1 in 12.
- OP_code=5 -> BRANCH with PCWriteCond=1, BranchNE=1, ALUOP=001. OP_code=13 -> IMM_EXEC with ALUOP=101, Sign=0.
- FETCH with mem_ready low 3 cycles then high -> MemRead=1 for 4 cycles, IRWrite pulse only in the 4th, then DECODE.
- mem_ready held 0 in MEM_WRITE (OP_code=43) -> TRAP exactly MEM_TIMEOUT=16 cycles after entry, bus_err=1. rst_n=0 -> FETCH, bus_err=0.
- OP_code=6'd63 -> TRAP after DECODE, illegal=1, PCWrite=0 thereafter. rst_n low during R_EXEC -> next state FETCH, RegWrite never asserted.
